// File: rtl/calc_undo_if.sv
// Operator-panel bundle for the undoable calculator: buttons and operand in,
// accumulator display and status out.
interface calc_undo_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic                         btnl;
    logic                         btnc;
    logic                         btnr;
    logic                         btnd;
    logic                         btnu;
    logic                         btn_undo;
    logic [WIDTH-1:0]             sw;
    logic [WIDTH-1:0]             led;
    logic                         ovf;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   hist_cnt;

    // The panel (or a bench) drives buttons and switches.
    modport master (
        output btnl, btnc, btnr, btnd, btnu, btn_undo, sw,
        input  led, ovf, busy, hist_cnt
    );

    // The calculator core consumes buttons and shows its state.
    modport slave (
        input  btnl, btnc, btnr, btnd, btnu, btn_undo, sw,
        output led, ovf, busy, hist_cnt
    );
endinterface

// File: rtl/calc_undo.sv
// Accumulating calculator with a bounded undo history. Single-cycle ALU ops,
// a WIDTH-cycle shift-add signed multiplier, and synchronised button edges.
module calc_undo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    calc_undo_if.slave    bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = 2 * WIDTH;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_ASR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic {IDLE, MUL} state_e;

    // Button conditioning: index 2 = clear, 1 = undo, 0 = execute.
    logic [2:0] btn_raw;
    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] prev;
    logic [2:0] pulse;
    logic       clr_p;
    logic       undo_p;
    logic       exec_p;

    // Architectural state.
    state_e            state;
    logic [WIDTH-1:0]  acc;
    logic              ovf;
    logic              busy;
    logic [CNT_W-1:0]  hist_cnt;
    logic [PTR_W-1:0]  top;
    logic [WIDTH-1:0]  hist_mem [DEPTH];

    // Multiplier datapath.
    logic [SH_W-1:0]   mul_cnt;
    logic [PW-1:0]     prod;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [PW-1:0]     partial;
    logic [PW-1:0]     prod_next;
    logic              mul_last;
    logic              mul_ovf;

    // ALU results.
    op_e               op;
    logic [SH_W-1:0]   shamt;
    logic [WIDTH:0]    sum_w;
    logic [WIDTH:0]    diff_w;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_ovf;

    // History control.
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic [WIDTH-1:0]  hist_top;
    logic              commit_exec;
    logic              mul_done;
    logic              push;
    logic              do_undo;

    assign btn_raw = {bus.btnu, bus.btn_undo, bus.btnd};

    // Two-flop synchroniser plus previous-value flop; all preset so a button
    // held through reset release cannot produce an edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!resetn) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Rising-edge pulses, resolved by priority clear > undo > execute.
    assign pulse  = sync2 & ~prev;
    assign clr_p  = pulse[2];
    assign undo_p = pulse[1] & ~pulse[2];
    assign exec_p = pulse[0] & ~pulse[1] & ~pulse[2];

    // Single-cycle ALU over acc (op1) and sw (op2), both signed.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        alu_res = '0;
        alu_ovf = 1'b0;
        op      = op_e'({bus.btnl, bus.btnc, bus.btnr});
        shamt   = bus.sw[SH_W-1:0];
        sum_w   = {acc[WIDTH-1], acc} + {bus.sw[WIDTH-1], bus.sw};
        diff_w  = {acc[WIDTH-1], acc} - {bus.sw[WIDTH-1], bus.sw};
        case (op)
            OP_ADD: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_ovf = sum_w[WIDTH] ^ sum_w[WIDTH-1];
            end
            OP_SUB: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_ovf = diff_w[WIDTH] ^ diff_w[WIDTH-1];
            end
            OP_AND:  alu_res = acc & bus.sw;
            OP_OR:   alu_res = acc | bus.sw;
            OP_XOR:  alu_res = acc ^ bus.sw;
            OP_SHL:  alu_res = acc << shamt;
            OP_ASR:  alu_res = $signed(acc) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // One shift-add step per cycle; the multiplier MSB carries negative
    // weight, so the last step subtracts to give the exact signed product.
    always_comb begin
        partial   = mplier[0] ? mcand : '0;
        mul_last  = (mul_cnt == SH_W'(WIDTH - 1));
        prod_next = mul_last ? (prod - partial) : (prod + partial);
        mul_ovf   = !((&prod_next[PW-1:WIDTH-1]) || !(|prod_next[PW-1:WIDTH-1]));
    end

    // Circular history: top points at the next free slot.
    always_comb begin
        top_inc     = (top == PTR_W'(DEPTH - 1)) ? '0 : top + PTR_W'(1);
        top_dec     = (top == '0) ? PTR_W'(DEPTH - 1) : top - PTR_W'(1);
        hist_top    = hist_mem[top_dec];
        commit_exec = (state == IDLE) && exec_p && (op != OP_MUL);
        mul_done    = (state == MUL) && mul_last;
        push        = clr_p || commit_exec || mul_done;
        do_undo     = (state == IDLE) && undo_p && (hist_cnt != '0);
    end

    // History storage; the pushed value is always the pre-commit accumulator.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; hist_cnt alone decides which entries are valid.
        if (push) begin
            hist_mem[top] <= acc;
        end
    end

    // Control FSM with registered accumulator, flags and history bookkeeping.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            acc      <= '0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            hist_cnt <= '0;
            top      <= '0;
            mul_cnt  <= '0;
            prod     <= '0;
            mcand    <= '0;
            mplier   <= '0;
        end else begin
            if (push) begin
                top <= top_inc;
                if (hist_cnt != CNT_W'(DEPTH)) begin
                    hist_cnt <= hist_cnt + CNT_W'(1);
                end
            end else if (do_undo) begin
                top      <= top_dec;
                hist_cnt <= hist_cnt - CNT_W'(1);
            end

            if (clr_p) begin
                acc   <= '0;
                ovf   <= 1'b0;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (undo_p) begin
                            if (do_undo) begin
                                acc <= hist_top;
                                ovf <= 1'b0;
                            end
                        end else if (exec_p) begin
                            if (op == OP_MUL) begin
                                state   <= MUL;
                                busy    <= 1'b1;
                                mul_cnt <= '0;
                                prod    <= '0;
                                mcand   <= {{WIDTH{acc[WIDTH-1]}}, acc};
                                mplier  <= bus.sw;
                            end else begin
                                acc <= alu_res;
                                ovf <= alu_ovf;
                            end
                        end
                    end
                    MUL: begin
                        prod    <= prod_next;
                        mcand   <= mcand << 1;
                        mplier  <= mplier >> 1;
                        mul_cnt <= mul_cnt + SH_W'(1);
                        if (mul_last) begin
                            acc   <= prod_next[WIDTH-1:0];
                            ovf   <= mul_ovf;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.led      = acc;
    assign bus.ovf      = ovf;
    assign bus.busy     = busy;
    assign bus.hist_cnt = hist_cnt;

endmodule

// File: tb/tb_calc_undo.sv
// Scoreboard bench for calc_undo (WIDTH=16, DEPTH=4): a behavioural model
// predicts each result, pushes it to a queue, and the queue is popped and
// compared once the DUT has had time to act.
module tb_calc_undo;
    typedef struct packed {
        logic [15:0] led;
        logic        ovf;
        logic        busy;
        logic [2:0]  cnt;
    } snap_t;

    logic clk;
    logic resetn;
    int   checks;
    int   failures;

    snap_t       exp_q[$];
    logic [15:0] m_acc;
    logic        m_ovf;
    logic [15:0] m_hist[$];

    calc_undo_if #(.WIDTH(16), .DEPTH(4)) bus ();

    calc_undo #(.WIDTH(16), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic snap_t sample();
        snap_t s;
        s.led  = bus.led;
        s.ovf  = bus.ovf;
        s.busy = bus.busy;
        s.cnt  = bus.hist_cnt;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.led  = m_acc;
        s.ovf  = m_ovf;
        s.busy = 1'b0;
        s.cnt  = 3'(m_hist.size());
        return s;
    endfunction

    function automatic void model_push();
        m_hist.push_back(m_acc);
        if (m_hist.size() > 4) m_hist.delete(0);
    endfunction

    function automatic void model_reset();
        m_acc = '0;
        m_ovf = 1'b0;
        m_hist.delete();
    endfunction

    function automatic void model_clear();
        model_push();
        m_acc = '0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_undo();
        if (m_hist.size() > 0) begin
            m_acc = m_hist.pop_back();
            m_ovf = 1'b0;
        end
    endfunction

    function automatic void model_exec(input logic [2:0] op, input logic [15:0] s);
        longint             a, b, p;
        logic [15:0]        r;
        logic signed [15:0] sa;
        logic               o;
        a = longint'($signed(m_acc));
        b = longint'($signed(s));
        p = 0;
        r = '0;
        o = 1'b0;
        case (op)
            3'd0: p = a + b;
            3'd1: p = a - b;
            3'd7: p = a * b;
            3'd2: r = m_acc & s;
            3'd3: r = m_acc | s;
            3'd4: r = m_acc ^ s;
            3'd5: r = m_acc << s[3:0];
            default: begin
                sa = m_acc;
                sa = sa >>> s[3:0];
                r  = sa;
            end
        endcase
        if (op == 3'd0 || op == 3'd1 || op == 3'd7) begin
            r = p[15:0];
            o = (p > 32767) || (p < -32768);
        end
        model_push();
        m_acc = r;
        m_ovf = o;
    endfunction

    task automatic set_op(input logic [2:0] op, input logic [15:0] s);
        bus.btnl = op[2];
        bus.btnc = op[1];
        bus.btnr = op[0];
        bus.sw   = s;
    endtask

    // Raise the chosen buttons for 'hold' cycles; returns at the negedge
    // following the edge where the press takes effect (or later if held long).
    task automatic press(input logic u, input logic un, input logic d, input int hold);
        @(negedge clk);
        bus.btnu     = u;
        bus.btn_undo = un;
        bus.btnd     = d;
        repeat (hold) @(negedge clk);
        bus.btnu     = 1'b0;
        bus.btn_undo = 1'b0;
        bus.btnd     = 1'b0;
        if (hold < 3) repeat (3 - hold) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        snap_t e, o;
        do_reset();
        exp_q.push_back(model_snap());
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_state: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        // Button held through reset release must not act.
        set_op(3'd0, 16'h0001);
        @(negedge clk);
        bus.btnd = 1'b1;
        resetn   = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        bus.btnd = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back(model_snap());
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL held_through_reset: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_add_latency();
        snap_t e, o;
        set_op(3'd0, 16'h0005);
        exp_q.push_back(model_snap());
        model_exec(3'd0, 16'h0005);
        exp_q.push_back(model_snap());
        @(negedge clk);
        bus.btnd = 1'b1;
        @(negedge clk);
        bus.btnd = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL add_edge_n1: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        @(negedge clk);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL add_edge_n2: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_ovf_undo();
        snap_t e, o;
        logic [15:0] sws [3] = '{16'h7FFF, 16'h0001, 16'h0000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                set_op(3'd0, sws[i]);
                model_exec(3'd0, sws[i]);
                exp_q.push_back(model_snap());
                press(1'b0, 1'b0, 1'b1, 1);
            end else begin
                model_undo();
                exp_q.push_back(model_snap());
                press(1'b0, 1'b1, 1'b0, 1);
            end
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ovf_undo[%0d]: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", i, o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_ops();
        snap_t e, o;
        logic [2:0]  ops [9] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd6};
        logic [15:0] sws [9] = '{16'h0002, 16'h8000, 16'h0F0F, 16'h1234, 16'hFFFF,
                                 16'h0003, 16'h0002, 16'h0010, 16'h000F};
        for (int i = 0; i < 9; i++) begin
            set_op(ops[i], sws[i]);
            model_exec(ops[i], sws[i]);
            exp_q.push_back(model_snap());
            press(1'b0, 1'b0, 1'b1, 1);
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL op%0d[%0d]: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", ops[i], i, o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_mul();
        snap_t e, o;
        int    busy_cycles;
        logic [15:0] pre;
        do_reset();
        set_op(3'd0, 16'h0003);
        model_exec(3'd0, 16'h0003);
        press(1'b0, 1'b0, 1'b1, 1);
        pre = m_acc;
        set_op(3'd7, 16'hFFFE);
        press(1'b0, 1'b0, 1'b1, 1);
        busy_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            if (bus.busy === 1'b1 && bus.led === pre) busy_cycles++;
            if (i == 2) bus.btnd = 1'b1;
            if (i == 3) bus.btnd = 1'b0;
            if (i == 8) bus.btn_undo = 1'b1;
            if (i == 9) bus.btn_undo = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 16) begin
            failures++;
            $display("FAIL mul_busy_hold: got %0d busy cycles with led held, want 16", busy_cycles);
        end
        model_exec(3'd7, 16'hFFFE);
        exp_q.push_back(model_snap());
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL mul_commit: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        // Overflowing product.
        set_op(3'd0, 16'h0106);
        model_exec(3'd0, 16'h0106);
        press(1'b0, 1'b0, 1'b1, 1);
        set_op(3'd7, 16'h0100);
        press(1'b0, 1'b0, 1'b1, 1);
        repeat (16) @(negedge clk);
        model_exec(3'd7, 16'h0100);
        exp_q.push_back(model_snap());
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL mul_ovf: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_history();
        snap_t e, o;
        do_reset();
        set_op(3'd0, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) begin
                model_exec(3'd0, 16'h0001);
                exp_q.push_back(model_snap());
                press(1'b0, 1'b0, 1'b1, 1);
            end else begin
                model_undo();
                exp_q.push_back(model_snap());
                press(1'b0, 1'b1, 1'b0, 1);
            end
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL history[%0d]: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", i, o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    task automatic test_held();
        snap_t e, o;
        set_op(3'd0, 16'h0001);
        model_exec(3'd0, 16'h0001);
        exp_q.push_back(model_snap());
        press(1'b0, 1'b0, 1'b1, 10);
        repeat (4) @(negedge clk);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL held_btnd: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_simultaneous();
        snap_t e, o;
        do_reset();
        set_op(3'd0, 16'h0042);
        model_exec(3'd0, 16'h0042);
        press(1'b0, 1'b0, 1'b1, 1);
        set_op(3'd0, 16'h0001);
        model_clear();
        exp_q.push_back(model_snap());
        press(1'b1, 1'b1, 1'b1, 1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL simul_clear: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        model_undo();
        exp_q.push_back(model_snap());
        press(1'b0, 1'b1, 1'b0, 1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL simul_undo: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_abort();
        snap_t e, o;
        // Clear during a multiply.
        set_op(3'd7, 16'h0003);
        press(1'b0, 1'b0, 1'b1, 1);
        repeat (3) @(negedge clk);
        model_clear();
        exp_q.push_back(model_snap());
        exp_q.push_back(model_snap());
        press(1'b1, 1'b0, 1'b0, 1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL clear_in_mul: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        repeat (20) @(negedge clk);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL clear_in_mul_late: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        model_undo();
        exp_q.push_back(model_snap());
        press(1'b0, 1'b1, 1'b0, 1);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL clear_in_mul_undo: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
        // Reset during a multiply.
        set_op(3'd7, 16'h0005);
        press(1'b0, 1'b0, 1'b1, 1);
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        exp_q.push_back(model_snap());
        repeat (20) @(negedge clk);
        e = exp_q.pop_front(); o = sample(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_in_mul: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        snap_t       e, o;
        int          act;
        logic [2:0]  op;
        logic [15:0] s;
        for (int i = 0; i < 24; i++) begin
            act = $urandom_range(0, 9);
            op  = 3'($urandom_range(0, 7));
            s   = 16'($urandom);
            set_op(op, s);
            if (act == 0) begin
                model_clear();
                exp_q.push_back(model_snap());
                press(1'b1, 1'b0, 1'b0, 1);
            end else if (act == 1) begin
                model_undo();
                exp_q.push_back(model_snap());
                press(1'b0, 1'b1, 1'b0, 1);
            end else begin
                model_exec(op, s);
                exp_q.push_back(model_snap());
                press(1'b0, 1'b0, 1'b1, 1);
                if (op == 3'd7) repeat (16) @(negedge clk);
            end
            e = exp_q.pop_front(); o = sample(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL b2b[%0d] act=%0d op=%0d sw=%h: got led=%h ovf=%b busy=%b cnt=%0d want led=%h ovf=%b busy=%b cnt=%0d", i, act, op, s, o.led, o.ovf, o.busy, o.cnt, e.led, e.ovf, e.busy, e.cnt);
            end
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        resetn       = 1'b0;
        bus.btnl     = 1'b0;
        bus.btnc     = 1'b0;
        bus.btnr     = 1'b0;
        bus.btnd     = 1'b0;
        bus.btnu     = 1'b0;
        bus.btn_undo = 1'b0;
        bus.sw       = '0;
        model_reset();

        test_reset();
        test_add_latency();
        test_ovf_undo();
        test_ops();
        test_mul();
        test_history();
        test_held();
        test_simultaneous();
        test_abort();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
